// File: rtl/rx_eth_header_parser.sv
// Ethernet RX header parser: captures dst/src MAC and EtherType from the FIFO byte
// stream, filters on the destination MAC, forwards accepted payload, discards the rest.
module rx_eth_header_parser #(
  parameter bit          ACCEPT_MCAST = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [47:0]      local_mac,
  input  logic             promisc,
  output logic             hdr_valid,
  output logic [47:0]      hdr_dst_mac,
  output logic [47:0]      hdr_src_mac,
  output logic [15:0]      hdr_ethertype,
  output logic             pl_valid,
  output logic [7:0]       pl_data,
  output logic             pl_last,
  input  logic             pl_ready,
  output logic             frame_drop,
  output logic             runt_err,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_drop
);

  typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DROP} state_e;

  localparam logic [3:0] LAST_HDR_IDX = 4'd13;

  state_e           state_q;
  logic [3:0]       idx_q;
  logic [47:0]      dst_q;
  logic [47:0]      src_q;
  logic [15:0]      type_q;
  logic             hdr_valid_q;
  logic             frame_drop_q;
  logic             runt_err_q;
  logic [CNT_W-1:0] cnt_ok_q;
  logic [CNT_W-1:0] cnt_drop_q;

  logic             in_hs;
  logic             accept;
  logic [CNT_W-1:0] cnt_ok_d;
  logic [CNT_W-1:0] cnt_drop_d;

  always_comb begin
    in_ready = 1'b1;
    pl_valid = 1'b0;
    pl_data  = '0;
    pl_last  = 1'b0;
    if (state_q == S_PAYLOAD) begin
      in_ready = pl_ready;
      pl_valid = in_valid;
      pl_data  = in_data;
      pl_last  = in_last;
    end
  end

  // dst bytes 0..5 are complete long before the filter runs at byte 13
  always_comb begin
    in_hs      = in_valid && in_ready;
    accept     = promisc || (dst_q == local_mac) || (dst_q == '1) ||
                 (ACCEPT_MCAST && dst_q[40]);
    cnt_ok_d   = (&cnt_ok_q)   ? cnt_ok_q   : cnt_ok_q   + CNT_W'(1);
    cnt_drop_d = (&cnt_drop_q) ? cnt_drop_q : cnt_drop_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HDR;
      idx_q        <= '0;
      dst_q        <= '0;
      src_q        <= '0;
      type_q       <= '0;
      hdr_valid_q  <= 1'b0;
      frame_drop_q <= 1'b0;
      runt_err_q   <= 1'b0;
      cnt_ok_q     <= '0;
      cnt_drop_q   <= '0;
    end else begin
      hdr_valid_q  <= 1'b0;
      frame_drop_q <= 1'b0;
      runt_err_q   <= 1'b0;
      case (state_q)
        S_HDR: begin
          if (in_hs) begin
            if (idx_q < 4'd6)       dst_q  <= {dst_q[39:0], in_data};
            else if (idx_q < 4'd12) src_q  <= {src_q[39:0], in_data};
            else                    type_q <= {type_q[7:0], in_data};

            if (in_last) begin
              runt_err_q <= 1'b1;
              cnt_drop_q <= cnt_drop_d;
              idx_q      <= '0;
            end else if (idx_q == LAST_HDR_IDX) begin
              idx_q <= '0;
              if (accept) begin
                hdr_valid_q <= 1'b1;
                state_q     <= S_PAYLOAD;
              end else begin
                frame_drop_q <= 1'b1;
                cnt_drop_q   <= cnt_drop_d;
                state_q      <= S_DROP;
              end
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        S_PAYLOAD: begin
          if (in_hs && in_last) begin
            cnt_ok_q <= cnt_ok_d;
            idx_q    <= '0;
            state_q  <= S_HDR;
          end
        end
        S_DROP: begin
          if (in_hs && in_last) begin
            idx_q   <= '0;
            state_q <= S_HDR;
          end
        end
        default: state_q <= S_HDR;
      endcase
    end
  end

  assign hdr_valid     = hdr_valid_q;
  assign hdr_dst_mac   = dst_q;
  assign hdr_src_mac   = src_q;
  assign hdr_ethertype = type_q;
  assign frame_drop    = frame_drop_q;
  assign runt_err      = runt_err_q;
  assign cnt_ok        = cnt_ok_q;
  assign cnt_drop      = cnt_drop_q;

endmodule
